// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-memory bus used by the responder and the
// core-side initiator: bus widths, the responder state encoding and the
// request payload captured at the accept handshake.
package dmem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Request payload held for the lifetime of one transaction.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_req_t;

endpackage : dmem_bus_pkg

// File: rtl/dmem_array.sv
// Word-organised storage with one byte-strobed write port and one
// combinational read port. Synchronous active-low clear of every word.
//
// Ports:
//   clk      - clock
//   start    - synchronous active-low reset (0 clears all words)
//   wr_en    - commit a write this edge
//   wr_idx   - word index written
//   wr_data  - write data, little-endian byte lanes
//   wr_strb  - byte enables, bit i enables wr_data[8i+7:8i]
//   rd_idx   - word index read
//   rd_data_c- combinational read data (registered by the parent)
module dmem_array
  import dmem_bus_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              start,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Storage update: full clear on reset, otherwise per-lane write.
  always_ff @(posedge clk) begin
    if (!start) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_c = mem[rd_idx];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time over a
// valid/ready request channel, waits WAIT_CYCLES wait states, commits the
// access on the edge entering RESP and holds the response until the
// initiator takes it. Misaligned or out-of-range accesses return rsp_err=1,
// rsp_rdata=0 and never touch storage.
//
// Ports:
//   clk       - clock
//   start     - synchronous active-low reset (0 = reset, 1 = run)
//   req_valid - request present
//   req_ready - request can be accepted (IDLE and not in reset)
//   req_write - 1 = store, 0 = load
//   req_addr  - byte address
//   req_wdata - store data
//   req_wstrb - store byte enables
//   rsp_valid - response present
//   rsp_ready - response accepted
//   rsp_rdata - load data (0 for stores and errors)
//   rsp_err   - misaligned or out-of-range access
module dmem_responder
  import dmem_bus_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0] SPAN_BYTES = (ADDR_W+1)'(DEPTH_WORDS * 4);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  logic              err_q, err_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

  dmem_req_t         txn;
  logic              txn_err;
  logic              enter_resp;
  logic              accept;
  logic [ADDR_W:0]   req_off;
  logic              req_err;
  logic [IDX_W-1:0]  txn_idx;
  logic [DATA_W-1:0] rd_word;

  assign req_ready = start & (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  // Address check on the live request; 33-bit offset so addr < BASE cannot wrap into range.
  always_comb begin
    req_off = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    req_err = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) | (req_off >= SPAN_BYTES);
  end

  // Next state, counter, request capture and response registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    enter_resp  = 1'b0;
    txn         = req_q;
    txn_err     = err_q;

    case (state_q)
      IDLE: begin
        // With zero wait states the commit edge is the accept edge, so use the live request.
        txn.write = req_write;
        txn.addr  = req_addr;
        txn.wdata = req_wdata;
        txn.wstrb = req_wstrb;
        txn_err   = req_err;
        if (accept) begin
          req_d = txn;
          err_d = req_err;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          enter_resp = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = (!txn.write && !txn_err) ? rd_word : '0;
      rsp_err_d   = txn_err;
    end
  end

  // Word index of the committing transaction.
  assign txn_idx = IDX_W'((txn.addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (!start) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      err_q     <= err_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .start    (start),
    .wr_en    (enter_resp & txn.write & ~txn_err),
    .wr_idx   (txn_idx),
    .wr_data  (txn.wdata),
    .wr_strb  (txn.wstrb),
    .rd_idx   (txn_idx),
    .rd_data_c(rd_word)
  );

endmodule : dmem_responder
